// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types: word type, fetch/decode payload width and the
// elastic stage-register state encoding.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  // next-PC word plus instruction word
  localparam int LC3B_FD_PAYLOAD_W = 32;

  typedef enum logic [1:0] {
    STAGE_EMPTY = 2'd0,
    STAGE_FULL  = 2'd1,
    STAGE_SKID  = 2'd2
  } stage_state_t;

  function automatic logic [1:0] stage_occupancy(input stage_state_t s);
    case (s)
      STAGE_FULL: stage_occupancy = 2'd1;
      STAGE_SKID: stage_occupancy = 2'd2;
      default:    stage_occupancy = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/register.sv
// Parametrised load-enable register with synchronous active-high reset.
module register #(
  parameter int                 WIDTH       = 16,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_reg;

  always_ff @(posedge clk) begin
    if (reset)
      data_reg <= RESET_VALUE;
    else if (load)
      data_reg <= d;
  end

  assign q = data_reg;

endmodule

// File: rtl/elastic_stage_register.sv
// Elastic pipeline stage: main slot plus one-entry skid slot, valid/ready
// handshake, synchronous flush. Optional counters with ELASTIC_STAGE_PERF_EN.
module elastic_stage_register
  import lc3b_types::*;
#(
  parameter int                      DATA_WIDTH = LC3B_FD_PAYLOAD_W,
  parameter logic [DATA_WIDTH-1:0]   RESET_DATA = '0,
  parameter int                      CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            occupancy
`ifdef ELASTIC_STAGE_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0]  stall_count,
  output logic [CNT_WIDTH-1:0]  flush_count
`endif
);

  stage_state_t state_reg;
  stage_state_t state_next;

  logic                  accept;
  logic                  consume;
  logic                  main_load;
  logic                  skid_load;
  logic [DATA_WIDTH-1:0] main_d;
  logic [DATA_WIDTH-1:0] skid_q;

  // Handshake outputs derive from the state register only, so out_ready never
  // reaches in_ready combinationally.
  assign in_ready  = (state_reg != STAGE_SKID);
  assign out_valid = (state_reg != STAGE_EMPTY);
  assign occupancy = stage_occupancy(state_reg);

  assign accept  = in_valid & in_ready;
  assign consume = out_valid & out_ready;

  always_comb begin
    state_next = state_reg;
    main_load  = 1'b0;
    skid_load  = 1'b0;
    case (state_reg)
      STAGE_EMPTY: begin
        if (accept) begin
          main_load  = 1'b1;
          state_next = STAGE_FULL;
        end
      end
      STAGE_FULL: begin
        if (accept && consume) begin
          main_load = 1'b1;
        end else if (accept) begin
          skid_load  = 1'b1;
          state_next = STAGE_SKID;
        end else if (consume) begin
          state_next = STAGE_EMPTY;
        end
      end
      STAGE_SKID: begin
        if (consume) begin
          main_load  = 1'b1;
          state_next = STAGE_FULL;
        end
      end
      default: state_next = STAGE_EMPTY;
    endcase
    // Flush squashes everything, including a same-cycle accept; slots keep data.
    if (flush) begin
      state_next = STAGE_EMPTY;
      main_load  = 1'b0;
      skid_load  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      state_reg <= STAGE_EMPTY;
    else
      state_reg <= state_next;
  end

  assign main_d = (state_reg == STAGE_SKID) ? skid_q : in_data;

  register #(
    .WIDTH       (DATA_WIDTH),
    .RESET_VALUE (RESET_DATA)
  ) u_main (
    .clk   (clk),
    .reset (reset),
    .load  (main_load),
    .d     (main_d),
    .q     (out_data)
  );

  register #(
    .WIDTH       (DATA_WIDTH),
    .RESET_VALUE (RESET_DATA)
  ) u_skid (
    .clk   (clk),
    .reset (reset),
    .load  (skid_load),
    .d     (in_data),
    .q     (skid_q)
  );

`ifdef ELASTIC_STAGE_PERF_EN
  logic [CNT_WIDTH-1:0] stall_count_reg;
  logic [CNT_WIDTH-1:0] flush_count_reg;

  // Both counters saturate at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count_reg <= '0;
      flush_count_reg <= '0;
    end else begin
      if (out_valid && !out_ready && !(&stall_count_reg))
        stall_count_reg <= stall_count_reg + 1'b1;
      if (flush && (state_reg != STAGE_EMPTY) && !(&flush_count_reg))
        flush_count_reg <= flush_count_reg + 1'b1;
    end
  end

  assign stall_count = stall_count_reg;
  assign flush_count = flush_count_reg;
`else
  logic unused_perf;
  assign unused_perf = (CNT_WIDTH > 0);
`endif

endmodule

// File: tb/tb_elastic_stage_register.sv
// Directed self-checking bench for elastic_stage_register; counter checks are
// compiled in when ELASTIC_STAGE_PERF_EN is defined.
module tb_elastic_stage_register;

  localparam int          DW    = 32;
  localparam logic [31:0] RDATA = 32'hDEAD_BEEF;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
`ifdef ELASTIC_STAGE_PERF_EN
  logic [1:0]    stall_count;
  logic [1:0]    flush_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  elastic_stage_register #(
    .DATA_WIDTH (DW),
    .RESET_DATA (RDATA),
    .CNT_WIDTH  (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
`ifdef ELASTIC_STAGE_PERF_EN
    ,
    .stall_count (stall_count),
    .flush_count (flush_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Advance one clock edge; inputs change and outputs are sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] v);
    in_valid = 1'b1;
    in_data  = v;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    step();
    step();
    reset = 1'b0;

    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_occupancy", {30'd0, occupancy}, 32'd0);
    check("rst_out_data",  out_data, RDATA);

    // Single transfer, 1-cycle latency
    out_ready = 1'b1;
    push(32'h1234_5678);
    check("t1_out_valid", {31'd0, out_valid}, 32'd1);
    check("t1_out_data",  out_data, 32'h1234_5678);
    check("t1_occupancy", {30'd0, occupancy}, 32'd1);
    step();
    check("t1_drained", {31'd0, out_valid}, 32'd0);

    // Streaming at full throughput
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = 32'(i);
      step();
      check($sformatf("t2_data_%0d", i), out_data, 32'(i));
      check($sformatf("t2_valid_%0d", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("t2_ready_%0d", i), {31'd0, in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    step();
    check("t2_drained", {31'd0, out_valid}, 32'd0);

    // Stall absorption into the skid slot
    out_ready = 1'b0;
    push(32'hA);
    check("t3_full_occ", {30'd0, occupancy}, 32'd1);
    push(32'hB);
    check("t3_skid_occ",   {30'd0, occupancy}, 32'd2);
    check("t3_skid_ready", {31'd0, in_ready},  32'd0);
    check("t3_skid_data",  out_data, 32'hA);
    in_valid = 1'b1; in_data = 32'hF;   // ignored while SKID
    step();
    in_valid = 1'b0;
    check("t3_stall_data", out_data, 32'hA);
    check("t3_stall_occ",  {30'd0, occupancy}, 32'd2);
    out_ready = 1'b1;
    step();
    check("t3_second_data", out_data, 32'hB);
    check("t3_second_occ",  {30'd0, occupancy}, 32'd1);
    step();
    check("t3_drained_occ", {30'd0, occupancy}, 32'd0);

    // Flush from SKID discards a same-cycle accept; slots keep their data
    out_ready = 1'b0;
    push(32'hD);
    push(32'hE);
    check("t4_pre_occ", {30'd0, occupancy}, 32'd2);
    flush = 1'b1; in_valid = 1'b1; in_data = 32'hC;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("t4_occ",       {30'd0, occupancy}, 32'd0);
    check("t4_out_valid", {31'd0, out_valid}, 32'd0);
    check("t4_in_ready",  {31'd0, in_ready},  32'd1);
    check("t4_main_kept", out_data, 32'hD);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("t4_no_c_%0d", i), {31'd0, out_valid}, 32'd0);
    end

    // Reset mid-stall drops both entries
    out_ready = 1'b0;
    push(32'h11);
    push(32'h22);
    check("t5_pre_occ", {30'd0, occupancy}, 32'd2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t5_out_valid", {31'd0, out_valid}, 32'd0);
    check("t5_occ",       {30'd0, occupancy}, 32'd0);
    check("t5_in_ready",  {31'd0, in_ready},  32'd1);
    check("t5_out_data",  out_data, RDATA);

`ifdef ELASTIC_STAGE_PERF_EN
    check("t6_stall_rst", {30'd0, stall_count}, 32'd0);
    check("t6_flush_rst", {30'd0, flush_count}, 32'd0);
    push(32'h55);
    for (int i = 0; i < 5; i++) step();
    check("t6_stall_sat", {30'd0, stall_count}, 32'd3);
    flush = 1'b1;
    step();
    check("t6_flush_full", {30'd0, flush_count}, 32'd1);
    step();
    flush = 1'b0;
    check("t6_flush_empty", {30'd0, flush_count}, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
